// File: rtl/frodo_pkg.sv
// Shared constants for the Frodo instruction front-end: opcodes, levels, row
// lengths, instruction field positions and the sequencer state type.
package frodo_pkg;

   localparam logic [2:0] OP_NOP   = 3'b000;
   localparam logic [2:0] OP_MUL   = 3'b100;
   localparam logic [2:0] OP_MULT  = 3'b101;
   localparam logic [2:0] OP_CODEC = 3'b110;

   localparam logic [1:0] LVL_640  = 2'd0;
   localparam logic [1:0] LVL_976  = 2'd1;
   localparam logic [1:0] LVL_1344 = 2'd2;

   localparam logic [7:0] LEN_640  = 8'd80;
   localparam logic [7:0] LEN_976  = 8'd122;
   localparam logic [7:0] LEN_1344 = 8'd168;

   localparam logic [2:0] CODEC_LAST = 3'd7;

   localparam int OPC_HI   = 26;
   localparam int OPC_LO   = 24;
   localparam int A_HI     = 23;
   localparam int A_LO     = 20;
   localparam int B_HI     = 19;
   localparam int B_LO     = 16;
   localparam int C_HI     = 15;
   localparam int C_LO     = 12;
   localparam int MODE_BIT = 11;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

   // Level 3 is not a real parameter set; it falls back to the largest row.
   function automatic logic [7:0] row_len(input logic [1:0] lvl);
      case (lvl)
         LVL_640:  return LEN_640;
         LVL_976:  return LEN_976;
         default:  return LEN_1344;
      endcase
   endfunction

   function automatic logic op_legal(input logic [2:0] opc);
      return (opc == OP_NOP) || (opc == OP_MUL) || (opc == OP_MULT) || (opc == OP_CODEC);
   endfunction

endpackage

// File: rtl/frodo_addr_gen.sv
// Row/word counters and buffer address formation. Reads are combinational from
// the counters; the write stream is the read stream delayed by one cycle.
module frodo_addr_gen
   import frodo_pkg::*;
#(
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic                  step,
   input  logic [2:0]            op_i,
   input  logic [ADDR_WIDTH-5:0] len_i,
   input  logic [3:0]            a_idx_i,
   input  logic [3:0]            b_idx_i,
   input  logic [3:0]            c_idx_i,
   output logic [ADDR_WIDTH-1:0] rd_addr_a,
   output logic [ADDR_WIDTH-1:0] rd_addr_b,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr_c,
   output logic [2:0]            row,
   output logic                  last
);
   localparam int OFF_W = ADDR_WIDTH - 4;

   logic [OFF_W-1:0]      j_q, j_d, len_q, len_d;
   logic [2:0]            r_q, r_d;
   logic [3:0]            a_q, a_d, b_q, b_d, c_q, c_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         j_q       <= '0;
         len_q     <= '0;
         r_q       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         c_q       <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
      end else begin
         j_q       <= j_d;
         len_q     <= len_d;
         r_q       <= r_d;
         a_q       <= a_d;
         b_q       <= b_d;
         c_q       <= c_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
      end
   end

   always_comb begin
      j_d   = j_q;
      r_d   = r_q;
      len_d = len_q;
      a_d   = a_q;
      b_d   = b_q;
      c_d   = c_q;
      if (start) begin
         j_d   = '0;
         r_d   = '0;
         len_d = len_i;
         a_d   = a_idx_i;
         b_d   = b_idx_i;
         c_d   = c_idx_i;
      end else if (step) begin
         // MUL walks words inside a row; MULT walks rows inside a word.
         case (op_i)
            OP_MULT: begin
               r_d = r_q + 3'd1;
               if (r_q == 3'd7) j_d = j_q + OFF_W'(1);
            end
            OP_CODEC: j_d = j_q + OFF_W'(1);
            default: begin
               if (j_q == len_q - OFF_W'(1)) begin
                  j_d = '0;
                  r_d = r_q + 3'd1;
               end else begin
                  j_d = j_q + OFF_W'(1);
               end
            end
         endcase
      end
      wr_en_d   = step;
      wr_addr_d = step ? {c_q, j_q} : '0;
   end

   always_comb begin
      rd_addr_a = (step && (op_i != OP_CODEC)) ? {a_q, j_q} : '0;
      rd_addr_b = step ? {b_q, j_q} : '0;
      last      = (op_i == OP_CODEC) ? (j_q == OFF_W'(CODEC_LAST))
                                     : ((r_q == 3'd7) && (j_q == len_q - OFF_W'(1)));
   end

   assign wr_en     = wr_en_q;
   assign wr_addr_c = wr_addr_q;
   assign row       = r_q;

endmodule

// File: rtl/frodo_top.sv
// Frodo instruction front-end: accepts one instruction, sequences the buffer
// address streams for it and reports done or err, guarded by a watchdog.
module frodo_top
   import frodo_pkg::*;
#(
   parameter int INST_WIDTH = 27,
   parameter int ADDR_WIDTH = 12,
   parameter int TIME       = 100000
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [INST_WIDTH-1:0] inst,
   input  logic                  inst_valid,
   input  logic [1:0]            level,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr_a,
   output logic [ADDR_WIDTH-1:0] rd_addr_b,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr_c,
   output logic [2:0]            op,
   output logic                  mode_o,
   output logic [2:0]            row
);
   localparam int WD_W  = $clog2(TIME + 1);
   localparam int OFF_W = ADDR_WIDTH - 4;

   state_t          state_q, state_d;
   logic [2:0]      op_q, op_d;
   logic            mode_q, mode_d;
   logic            err_q, err_d;
   logic [WD_W-1:0] wd_q, wd_d, wd_next;
   logic            accept, start, last;
   logic [2:0]      opc;
   logic            unused_rsvd;

   assign opc         = inst[OPC_HI:OPC_LO];
   assign accept      = inst_valid && !busy;
   assign unused_rsvd = ^inst[MODE_BIT-1:0];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         mode_q  <= 1'b0;
         err_q   <= 1'b0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         mode_q  <= mode_d;
         err_q   <= err_d;
         wd_q    <= wd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      mode_d  = mode_q;
      err_d   = 1'b0;
      wd_d    = wd_q;
      start   = 1'b0;
      wd_next = wd_q + WD_W'(1);
      case (state_q)
         ST_ISSUE: if (last) state_d = ST_DRAIN;
         ST_DRAIN: state_d = ST_DONE;
         default: begin
            // DONE is not busy, so a back-to-back instruction lands here too.
            state_d = ST_IDLE;
            if (accept) begin
               if (!op_legal(opc)) begin
                  err_d = 1'b1;
               end else begin
                  op_d   = opc;
                  mode_d = inst[MODE_BIT];
                  if (opc == OP_NOP) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_ISSUE;
                     start   = 1'b1;
                     wd_d    = WD_W'(1);
                  end
               end
            end
         end
      endcase
      if (busy) begin
         if (inst_valid) err_d = 1'b1;
         // wd_q holds the number of busy cycles seen so far, counting this one.
         if (wd_next == WD_W'(TIME)) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
         end else begin
            wd_d = wd_next;
         end
      end
   end

   always_comb begin
      busy  = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
      rd_en = (state_q == ST_ISSUE);
      done  = (state_q == ST_DONE);
   end

   assign err    = err_q;
   assign op     = op_q;
   assign mode_o = mode_q;

   frodo_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
      .clk       (clk),
      .rstn      (rstn),
      .start     (start),
      .step      (rd_en),
      .op_i      (op_q),
      .len_i     (OFF_W'(row_len(level))),
      .a_idx_i   (inst[A_HI:A_LO]),
      .b_idx_i   (inst[B_HI:B_LO]),
      .c_idx_i   (inst[C_HI:C_LO]),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .wr_en     (wr_en),
      .wr_addr_c (wr_addr_c),
      .row       (row),
      .last      (last)
   );

endmodule

// File: tb/tb_frodo_top.sv
// Directed bench for frodo_top: address streams, completion timing, error
// pulses, watchdog abort (second instance with a short limit) and mid-run reset.
module tb_frodo_top;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [26:0] inst = '0;
   logic        inst_valid = 1'b0;
   logic        inst_valid_w = 1'b0;
   logic [1:0]  level = '0;
   logic [26:0] drop_inst = '0;

   logic        busy, done, err, rd_en, wr_en, mode_o;
   logic [11:0] rd_addr_a, rd_addr_b, wr_addr_c;
   logic [2:0]  op, row;
   logic        busy_w, done_w, err_w, rd_en_w, wr_en_w, mode_w;
   logic [11:0] rd_addr_a_w, rd_addr_b_w, wr_addr_c_w;
   logic [2:0]  op_w, row_w;

   int checks = 0;
   int errors = 0;

   int first_a, first_b, first_wr, last_wr, n_rd, n_err, err_cyc, done_cyc;
   int busy_seen, busy1, seq_err, done_op, done_mode;
   int wd_err_cyc, wd_busy49, wd_busy50, wd_done, wd_nerr;
   logic [11:0] exp_q[$];

   frodo_top dut (
      .clk(clk), .rstn(rstn), .inst(inst), .inst_valid(inst_valid), .level(level),
      .busy(busy), .done(done), .err(err), .rd_en(rd_en), .rd_addr_a(rd_addr_a),
      .rd_addr_b(rd_addr_b), .wr_en(wr_en), .wr_addr_c(wr_addr_c), .op(op),
      .mode_o(mode_o), .row(row)
   );

   frodo_top #(.TIME(50)) dut_w (
      .clk(clk), .rstn(rstn), .inst(inst), .inst_valid(inst_valid_w), .level(level),
      .busy(busy_w), .done(done_w), .err(err_w), .rd_en(rd_en_w), .rd_addr_a(rd_addr_a_w),
      .rd_addr_b(rd_addr_b_w), .wr_en(wr_en_w), .wr_addr_c(wr_addr_c_w), .op(op_w),
      .mode_o(mode_w), .row(row_w)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [26:0] mk(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                                      input logic [3:0] c, input logic m);
      return {o, a, b, c, m, 11'h5A5};
   endfunction

   // Called on a falling edge; returns on the falling edge of cycle 1.
   task automatic issue(input logic [26:0] i, input logic [1:0] lv, input bit to_w);
      inst  = i;
      level = lv;
      if (to_w) inst_valid_w = 1'b1;
      else inst_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      inst_valid   = 1'b0;
      inst_valid_w = 1'b0;
   endtask

   // Observes cycles 1..limit on falling edges; stops at the done cycle.
   task automatic collect(input logic [2:0] opc, input int len, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] c, input int limit,
                          input int drop_cyc);
      int s, j, r;
      logic [11:0] ea, eb, ec, got;
      s = 0; n_rd = 0; n_err = 0; err_cyc = -1; done_cyc = -1; busy_seen = 0; busy1 = 0;
      seq_err = 0; first_a = -1; first_b = -1; first_wr = -1; last_wr = -1;
      done_op = -1; done_mode = -1;
      exp_q.delete();
      for (int cyc = 1; cyc <= limit; cyc++) begin
         if (cyc == 1) busy1 = int'(busy);
         if (busy) busy_seen = 1;
         if (err) begin
            n_err++;
            if (err_cyc < 0) err_cyc = cyc;
         end
         if (rd_en) begin
            case (opc)
               3'b101:  begin j = s / 8; r = s % 8; end
               3'b110:  begin j = s; r = 0; end
               default: begin j = s % len; r = s / len; end
            endcase
            ea = (opc == 3'b110) ? 12'h000 : {a, 8'(j)};
            eb = {b, 8'(j)};
            ec = {c, 8'(j)};
            if (n_rd == 0) begin
               first_a = int'(rd_addr_a);
               first_b = int'(rd_addr_b);
            end
            if (rd_addr_a !== ea || rd_addr_b !== eb || row !== 3'(r)) seq_err++;
            exp_q.push_back(ec);
            s++;
            n_rd++;
         end
         if (wr_en) begin
            if (exp_q.size() == 0) seq_err++;
            else begin
               got = exp_q.pop_front();
               if (wr_addr_c !== got) seq_err++;
            end
            if (first_wr < 0) first_wr = int'(wr_addr_c);
            last_wr = int'(wr_addr_c);
         end
         if (done) begin
            done_cyc  = cyc;
            done_op   = int'(op);
            done_mode = int'(mode_o);
            if (busy) seq_err++;
            inst_valid = 1'b0;
            break;
         end
         inst_valid = (cyc == drop_cyc);
         if (cyc == drop_cyc) inst = drop_inst;
         if (cyc < limit) @(negedge clk);
      end
      inst_valid = 1'b0;
      if (done_cyc >= 0 && exp_q.size() != 0) seq_err++;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ctl", 32'({busy, done, err, rd_en, wr_en, op, mode_o, row}), 32'h0);
      chk("rst_addr", 32'({rd_addr_a, rd_addr_b, wr_addr_c}), 32'h0);
      chk("rst_ctl_w", 32'({busy_w, done_w, err_w, rd_en_w, wr_en_w, op_w, mode_w, row_w}), 32'h0);
      rstn = 1'b1;
      @(negedge clk);

      // MUL, level 1 (L=122): K=976, done at 978
      issue(mk(3'b100, 4'h1, 4'h2, 4'h3, 1'b0), 2'd1, 1'b0);
      collect(3'b100, 122, 4'h1, 4'h2, 4'h3, 1100, 0);
      chk("mul_busy1", busy1, 1);
      chk("mul_first_a", first_a, 32'h100);
      chk("mul_first_b", first_b, 32'h200);
      chk("mul_n_rd", n_rd, 976);
      chk("mul_last_wr", last_wr, 32'h379);
      chk("mul_done_cyc", done_cyc, 978);
      chk("mul_seq", seq_err, 0);
      chk("mul_no_err", n_err, 0);
      chk("mul_op", done_op, 4);

      // CODEC encode right on the done cycle, level 2, B=0, C=2
      issue(mk(3'b110, 4'h5, 4'h0, 4'h2, 1'b0), 2'd2, 1'b0);
      collect(3'b110, 168, 4'h5, 4'h0, 4'h2, 20, 0);
      chk("enc_first_a", first_a, 32'h000);
      chk("enc_first_b", first_b, 32'h000);
      chk("enc_n_rd", n_rd, 8);
      chk("enc_first_wr", first_wr, 32'h200);
      chk("enc_last_wr", last_wr, 32'h207);
      chk("enc_done_cyc", done_cyc, 10);
      chk("enc_seq", seq_err, 0);
      chk("enc_mode", done_mode, 0);
      chk("enc_op", done_op, 6);

      // CODEC decode, C=3
      issue(mk(3'b110, 4'h5, 4'h0, 4'h3, 1'b1), 2'd2, 1'b0);
      collect(3'b110, 168, 4'h5, 4'h0, 4'h3, 20, 0);
      chk("dec_first_wr", first_wr, 32'h300);
      chk("dec_last_wr", last_wr, 32'h307);
      chk("dec_done_cyc", done_cyc, 10);
      chk("dec_seq", seq_err, 0);
      chk("dec_mode", done_mode, 1);

      // Illegal opcode 3'b011
      issue(mk(3'b011, 4'h1, 4'h2, 4'h3, 1'b0), 2'd0, 1'b0);
      collect(3'b011, 80, 4'h1, 4'h2, 4'h3, 5, 0);
      chk("ill_err_cyc", err_cyc, 1);
      chk("ill_n_err", n_err, 1);
      chk("ill_busy", busy_seen, 0);
      chk("ill_no_done", done_cyc, -1);
      chk("ill_no_rd", n_rd, 0);

      // MUL level 0 (L=80) with a second inst_valid at cycle 5
      drop_inst = mk(3'b110, 4'h0, 4'h0, 4'h0, 1'b0);
      issue(mk(3'b100, 4'hA, 4'hB, 4'hC, 1'b0), 2'd0, 1'b0);
      collect(3'b100, 80, 4'hA, 4'hB, 4'hC, 700, 5);
      chk("drop_err_cyc", err_cyc, 6);
      chk("drop_n_err", n_err, 1);
      chk("drop_n_rd", n_rd, 640);
      chk("drop_last_wr", last_wr, 32'hC4F);
      chk("drop_done_cyc", done_cyc, 642);
      chk("drop_seq", seq_err, 0);

      // NOP accepted on the done cycle
      issue(mk(3'b000, 4'h0, 4'h0, 4'h0, 1'b0), 2'd0, 1'b0);
      collect(3'b000, 80, 4'h0, 4'h0, 4'h0, 5, 0);
      chk("nop_done_cyc", done_cyc, 1);
      chk("nop_busy", busy_seen, 0);
      chk("nop_n_rd", n_rd, 0);

      // MULT, level 3 treated as L=168: K=1344
      issue(mk(3'b101, 4'h4, 4'h5, 4'h6, 1'b0), 2'd3, 1'b0);
      collect(3'b101, 168, 4'h4, 4'h5, 4'h6, 1400, 0);
      chk("mult_first_a", first_a, 32'h400);
      chk("mult_n_rd", n_rd, 1344);
      chk("mult_last_wr", last_wr, 32'h6A7);
      chk("mult_done_cyc", done_cyc, 1346);
      chk("mult_seq", seq_err, 0);

      // Watchdog on the TIME=50 instance
      issue(mk(3'b100, 4'h1, 4'h2, 4'h3, 1'b0), 2'd0, 1'b1);
      wd_err_cyc = -1; wd_busy49 = 0; wd_busy50 = 1; wd_done = 0; wd_nerr = 0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         if (cyc == 49) wd_busy49 = int'(busy_w);
         if (cyc == 50) wd_busy50 = int'(busy_w);
         if (err_w) begin
            wd_nerr++;
            if (wd_err_cyc < 0) wd_err_cyc = cyc;
         end
         if (done_w) wd_done++;
         @(negedge clk);
      end
      chk("wd_err_cyc", wd_err_cyc, 50);
      chk("wd_busy49", wd_busy49, 1);
      chk("wd_busy50", wd_busy50, 0);
      chk("wd_no_done", wd_done, 0);
      chk("wd_n_err", wd_nerr, 1);

      // Reset pulled at cycle 100 of a MUL
      issue(mk(3'b100, 4'h7, 4'h8, 4'h9, 1'b0), 2'd2, 1'b0);
      collect(3'b100, 168, 4'h7, 4'h8, 4'h9, 100, 0);
      chk("rmid_n_rd", n_rd, 100);
      chk("rmid_seq", seq_err, 0);
      rstn = 1'b0;
      #1;
      chk("rmid_ctl", 32'({busy, done, err, rd_en, wr_en, op, mode_o, row}), 32'h0);
      chk("rmid_addr", 32'({rd_addr_a, rd_addr_b, wr_addr_c}), 32'h0);
      @(negedge clk);
      chk("rmid_hold", 32'({busy, done, err, rd_en, wr_en}), 32'h0);
      rstn = 1'b1;
      issue(mk(3'b110, 4'h0, 4'h1, 4'h3, 1'b1), 2'd0, 1'b0);
      collect(3'b110, 80, 4'h0, 4'h1, 4'h3, 20, 0);
      chk("post_first_b", first_b, 32'h100);
      chk("post_last_wr", last_wr, 32'h307);
      chk("post_done_cyc", done_cyc, 10);
      chk("post_seq", seq_err, 0);
      chk("post_no_err", n_err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
